// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: constants, the fetch
// FSM encoding and the {instr, pc} packet handed to the decoder.
package fetch_unit_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int          FETCH_PKT_W      = 64;

  typedef enum logic {
    RST_HOLD = 1'b0,
    RUN      = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_pkt_t;

  // Force a fetch address onto a word boundary.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bus bundle of the fetch stage: instruction-memory request/response,
// redirect input and the decoder-facing instruction stream.
//
// Handshake rules: a transfer happens on a rising clock edge where both
// valid and ready are high. A request valid may be withdrawn before it is
// accepted; the memory samples imem_req_addr only on valid&ready. Memory
// responses have no ready: imem_rsp_valid returns one word per cycle, in
// request order, at least one cycle after acceptance. Redirect is a
// single-cycle pulse sampled at the clock edge.
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [31:0] pc_out;

  modport master (
    output imem_req_valid, imem_req_addr, instr_valid, instr_out, pc_out,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, instr_valid, instr_out, pc_out,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, instr_ready
  );
endinterface

// File: rtl/fetch_unit_fifo.sv
// fetch_fifo: small synchronous FIFO with push, pop, flush and occupancy.
// DEPTH must be a power of two (>= 2). A pop on an empty FIFO is ignored;
// a push on a full FIFO is accepted only when a pop frees a slot in the same
// cycle. Flush empties the FIFO and overrides push/pop.
module fetch_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_push,
  input  logic [W-1:0]           i_data,
  input  logic                   i_pop,
  input  logic                   i_flush,
  output logic [W-1:0]           o_data,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_empty;
  logic          w_full;
  logic          w_do_push;
  logic          w_do_pop;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == (AW+1)'(DEPTH));
  assign w_do_pop  = i_pop && !w_empty;
  assign w_do_push = i_push && (!w_full || w_do_pop);

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge i_clk) begin
    if (w_do_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Keeps the PC, issues word requests to
// instruction memory under a credit limit of FIFO_DEPTH, buffers returned
// words with their PCs and streams {instr, pc} to decode. Redirects flush the
// buffer and mark in-flight requests for discard.
// Optional build macro: FETCH_PERF_EN adds perf_fetch_cnt / perf_stall_cnt.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_unit_if.master  bus,
  output fetch_state_t  dbg_state
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]   perf_fetch_cnt,
  output logic [31:0]   perf_stall_cnt
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_L = (CW+1)'(FIFO_DEPTH);

  logic         r_sync1;
  logic         r_sync2;
  logic         w_rst_n;

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_discard;
  logic [31:0]  r_pc_last;

  logic         w_accept;
  logic         w_rsp;
  logic         w_keep;
  logic         w_pop;
  logic         w_flush;
  logic         w_ifq_empty;
  logic         w_ifq_full;
  logic         w_ifq_push;
  logic [CW-1:0] w_ifq_count;
  logic [CW-1:0] w_sq_count;
  logic [31:0]  w_sq_head;
  logic [CW-1:0] w_out_next;
  logic [CW:0]  w_occupancy;
  fetch_pkt_t   w_ifq_in;
  fetch_pkt_t   w_head;

  // Reset synchronizer: assert immediately, release two edges later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= 1'b1;
      r_sync2 <= r_sync1;
    end
  end
  assign w_rst_n = r_sync2;

  assign w_flush     = bus.redirect_valid;
  assign w_rsp       = bus.imem_rsp_valid;
  assign w_ifq_empty = (w_ifq_count == '0);
  assign w_ifq_full  = (w_ifq_count == CW'(FIFO_DEPTH));
  assign w_pop       = !w_ifq_empty && bus.instr_ready;

  // Credit counts the buffer slot freed by this cycle's pop so a depth-2
  // buffer with 1-cycle memory can sustain one instruction per cycle; the
  // invariant outstanding + buffered <= FIFO_DEPTH still holds after the edge.
  assign w_occupancy = {1'b0, r_outstanding} + {1'b0, w_ifq_count}
                     - {{CW{1'b0}}, w_pop};

  assign bus.imem_req_valid = (r_state == RUN) && !bus.redirect_valid
                            && (w_occupancy < DEPTH_L);
  assign bus.imem_req_addr  = r_pc;
  assign w_accept           = bus.imem_req_valid && bus.imem_req_ready;

  // A response is kept only when nothing is pending discard, no redirect is
  // squashing this cycle, and an accepted address is on record for it.
  assign w_keep     = w_rsp && (r_discard == '0) && !w_flush && (w_sq_count != '0);
  assign w_ifq_push = w_keep;
  assign w_ifq_in   = '{instr: bus.imem_rsp_data, pc: w_sq_head};

  assign w_out_next = r_outstanding + CW'(w_accept) - CW'(w_rsp);

  // Shadow queue of accepted fetch addresses, popped by kept responses.
  fetch_fifo #(
    .W     (32),
    .DEPTH (FIFO_DEPTH)
  ) u_pc_queue (
    .i_clk   (clk),
    .i_rst_n (w_rst_n),
    .i_push  (w_accept),
    .i_data  (r_pc),
    .i_pop   (w_keep),
    .i_flush (w_flush),
    .o_data  (w_sq_head),
    .o_count (w_sq_count)
  );

  // Instruction buffer feeding the decoder.
  fetch_fifo #(
    .W     (FETCH_PKT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_instr_fifo (
    .i_clk   (clk),
    .i_rst_n (w_rst_n),
    .i_push  (w_ifq_push),
    .i_data  (w_ifq_in),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .o_data  (w_head),
    .o_count (w_ifq_count)
  );

  // Fetch FSM with PC, outstanding-request and discard counters.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state       <= RST_HOLD;
      r_pc          <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      r_outstanding <= w_out_next;
      case (r_state)
        RST_HOLD: begin
          r_state <= RUN;
          if (bus.redirect_valid) r_pc <= align_pc(bus.redirect_pc);
        end
        RUN: begin
          if (bus.redirect_valid) begin
            r_pc      <= align_pc(bus.redirect_pc);
            r_discard <= w_out_next;
          end else begin
            if (w_accept) r_pc <= r_pc + 32'd4;
            if (w_rsp && (r_discard != '0)) r_discard <= r_discard - CW'(1);
          end
        end
        default: r_state <= RST_HOLD;
      endcase
    end
  end

  // Remember the last presented PC so pc_out holds while the buffer is empty.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_pc_last <= 32'h0;
    end else if (!w_ifq_empty) begin
      r_pc_last <= w_head.pc;
    end
  end

  assign bus.instr_valid = !w_ifq_empty;
  assign bus.instr_out   = w_ifq_empty ? NOP_INSTR : w_head.instr;
  assign bus.pc_out      = w_ifq_empty ? r_pc_last : w_head.pc;
  assign dbg_state       = r_state;

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetch;
  logic [31:0] r_perf_stall;

  // Delivered-instruction and decoder-starvation counters.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_perf_fetch <= 32'h0;
      r_perf_stall <= 32'h0;
    end else begin
      if (w_pop) r_perf_fetch <= r_perf_fetch + 32'd1;
      if ((r_state == RUN) && bus.instr_ready && w_ifq_empty)
        r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_fetch_cnt = r_perf_fetch;
  assign perf_stall_cnt = r_perf_stall;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: in-order memory model with programmable latency,
// expected-packet queue filled on request acceptance and drained on decoder
// pops, plus directed redirect / wrap / back-pressure scenarios.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if bus();
  fetch_state_t dbg_state;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  // ---------------- scoreboard state ----------------
  typedef struct {
    int          due;
    logic [31:0] addr;
  } mreq_t;

  logic [63:0] exp_q[$];
  mreq_t       mq[$];
  int          cyc = 0;
  int          mem_lat = 1;
  int          acc_count = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_5A00;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic apply_reset(input logic rdy);
    step();
    rst_n = 1'b0;
    exp_q.delete();
    acc_count = 0;
    bus.instr_ready = rdy;
    repeat (3) step();
    rst_n = 1'b1;
  endtask

  // One-cycle redirect pulse, called at posedge+2.
  task automatic do_redirect(input logic [31:0] tgt);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = tgt;
    @(negedge clk);
    check("redir_noreq", {63'h0, bus.imem_req_valid}, 64'h0);
    step();
    bus.redirect_valid = 1'b0;
  endtask

  // ---------------- memory model ----------------
  // Handshakes are sampled just before the rising edge; responses are driven
  // 1 time unit after the edge, in order, one per cycle.
  initial begin
    logic        l_acc;
    logic        l_redir;
    logic [31:0] l_addr;
    mreq_t       m;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    forever begin
      @(negedge clk);
      #4;
      l_acc   = rst_n && bus.imem_req_valid && bus.imem_req_ready;
      l_redir = rst_n && bus.redirect_valid;
      l_addr  = bus.imem_req_addr;
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        mq.delete();
      end else begin
        if (l_redir) exp_q.delete();
        if (l_acc) begin
          m.due  = cyc + mem_lat - 1;
          m.addr = l_addr;
          mq.push_back(m);
          exp_q.push_back({mem_word(l_addr), l_addr});
          acc_count++;
        end
      end
      #1;
      if (rst_n && mq.size() != 0 && mq[0].due <= cyc) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = mem_word(mq[0].addr);
        void'(mq.pop_front());
      end else begin
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
      end
    end
  end

  // ---------------- decoder-side monitor ----------------
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      #4;
      if (rst_n && bus.instr_valid && bus.instr_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_pop", {bus.instr_out, bus.pc_out}, 64'h0);
        end else begin
          e = exp_q.pop_front();
          check("sb_pkt", {bus.instr_out, bus.pc_out}, e);
        end
      end
    end
  end

  // Buffer must never be pushed while full without a simultaneous pop.
  always @(negedge clk) begin
    if (rst_n) begin
      assert (!(dut.w_ifq_push && dut.w_ifq_full && !dut.w_pop))
        else $error("FAIL fifo_overflow count=%0d", dut.w_ifq_count);
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation timeout");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int  n;
    bit  found;

    bus.imem_req_ready = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.instr_ready    = 1'b0;
    rst_n              = 1'b0;
    repeat (3) @(posedge clk);

    // Reset state.
    @(negedge clk);
    check("rst_instr_valid", {63'h0, bus.instr_valid}, 64'h0);
    check("rst_instr_out", {32'h0, bus.instr_out}, {32'h0, NOP_INSTR});
    check("rst_pc_out", {32'h0, bus.pc_out}, 64'h0);
    check("rst_req_valid", {63'h0, bus.imem_req_valid}, 64'h0);
    check("rst_state", {63'h0, dbg_state}, {63'h0, RST_HOLD});

    // Streaming from RESET_PC, 1-cycle memory, decoder always ready.
    step();
    bus.instr_ready = 1'b1;
    rst_n = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (bus.imem_req_valid) found = 1'b1;
    end
    check("t1_req_seen", {63'h0, found}, 64'h1);
    check("t1_first_addr", {32'h0, bus.imem_req_addr}, 64'h0);
    n = 0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      n++;
      if (bus.instr_valid) found = 1'b1;
    end
    check("t1_valid_latency", 64'(n), 64'd2);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.instr_valid && bus.instr_ready) n++;
    end
    check("t1_throughput", 64'(n), 64'd10);
    check("t1_state_run", {63'h0, dbg_state}, {63'h0, RUN});

    // Decoder stalled from reset: only FIFO_DEPTH requests accepted.
    apply_reset(1'b0);
    repeat (12) step();
    @(negedge clk);
    check("t2_accepts", 64'(acc_count), 64'd2);
    check("t2_req_dropped", {63'h0, bus.imem_req_valid}, 64'h0);
    check("t2_valid", {63'h0, bus.instr_valid}, 64'h1);
    check("t2_head", {bus.instr_out, bus.pc_out}, {mem_word(32'h0), 32'h0});
    step();
    bus.instr_ready = 1'b1;
    repeat (6) step();

    // 3-cycle memory, redirect with two requests in flight.
    mem_lat = 3;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (mq.size() == 2) found = 1'b1;
    end
    check("t3_two_inflight", {63'h0, found}, 64'h1);
    do_redirect(32'h0000_0100);
    @(negedge clk);
    check("t3_flushed", {63'h0, bus.instr_valid}, 64'h0);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (bus.instr_valid) found = 1'b1;
    end
    check("t3_valid_seen", {63'h0, found}, 64'h1);
    check("t3_target_pc", {32'h0, bus.pc_out}, 64'h100);
    step();
    mem_lat = 1;
    repeat (4) step();

    // Redirect colliding with a response and a decoder pop.
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (bus.imem_rsp_valid && bus.instr_valid) found = 1'b1;
    end
    check("t4_collision_seen", {63'h0, found}, 64'h1);
    do_redirect(32'h0000_0400);
    @(negedge clk);
    check("t4_flushed", {63'h0, bus.instr_valid}, 64'h0);
    check("t4_first_req", {31'h0, bus.imem_req_valid, bus.imem_req_addr},
          {31'h0, 1'b1, 32'h0000_0400});

    // Unaligned target and PC wrap.
    step();
    do_redirect(32'h0000_0203);
    @(negedge clk);
    check("t5_aligned", {31'h0, bus.imem_req_valid, bus.imem_req_addr},
          {31'h0, 1'b1, 32'h0000_0200});
    step();
    do_redirect(32'hFFFF_FFFC);
    @(negedge clk);
    check("t5_top_addr", {31'h0, bus.imem_req_valid, bus.imem_req_addr},
          {31'h0, 1'b1, 32'hFFFF_FFFC});
    step();
    @(negedge clk);
    check("t5_wrap_addr", {31'h0, bus.imem_req_valid, bus.imem_req_addr},
          {31'h0, 1'b1, 32'h0000_0000});

    // Random decoder back-pressure, then drain.
    for (int i = 0; i < 60; i++) begin
      step();
      bus.instr_ready = ($urandom_range(0, 3) != 0);
      mem_lat = $urandom_range(1, 3);
    end
    step();
    bus.instr_ready = 1'b1;
    bus.imem_req_ready = 1'b0;
    repeat (12) step();
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    check("drain_no_valid", {63'h0, bus.instr_valid}, 64'h0);
    bus.imem_req_ready = 1'b1;
    mem_lat = 1;

`ifdef FETCH_PERF_EN
    // Performance counters: 3 starved cycles, then 5 single pops.
    bus.imem_req_ready = 1'b0;
    apply_reset(1'b0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (dbg_state == RUN) found = 1'b1;
    end
    check("perf_run_seen", {63'h0, found}, 64'h1);
    bus.instr_ready = 1'b1;
    repeat (3) step();
    bus.instr_ready = 1'b0;
    bus.imem_req_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
        @(negedge clk);
        if (bus.instr_valid) found = 1'b1;
      end
      check("perf_pop_ready", {63'h0, found}, 64'h1);
      bus.instr_ready = 1'b1;
      step();
      bus.instr_ready = 1'b0;
    end
    step();
    check("perf_fetch_cnt", {32'h0, perf_fetch_cnt}, 64'd5);
    check("perf_stall_cnt", {32'h0, perf_stall_cnt}, 64'd3);
    rst_n = 1'b0;
    #1;
    check("perf_fetch_clr", {32'h0, perf_fetch_cnt}, 64'd0);
    check("perf_stall_clr", {32'h0, perf_stall_cnt}, 64'd0);
    exp_q.delete();
    step();
    rst_n = 1'b1;
    repeat (3) step();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
